// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared mips16 instruction/data memory port between fetch (I) and load/store (D).
// Optional ARB_WDOG_EN adds a mem_ready watchdog that aborts stuck accesses and pulses err_o.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic d_we_i,
  input  logic mem_ready_i,
  output logic mem_req_o,
  output logic mem_we_o,
  output logic addr_sel_o,
  output logic if_ack_o,
  output logic d_ack_o,
  output logic busy_o,
  output logic err_o
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic       addr_sel_q, addr_sel_d;
  logic       busy_q, busy_d;
  logic       abort;

`ifdef ARB_WDOG_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  assign abort = (state_q != StIdle) && !mem_ready_i && (wait_cnt_q == WaitLast);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StIdle) begin
      wait_cnt_d = '0;
    end else if (!mem_ready_i) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    addr_sel_d   = addr_sel_q;
    busy_d       = busy_q;
    unique case (state_q)
      StIdle: begin
        // Fetch wins only once data has hogged the port STARVE_MAX times in a row.
        if (if_req_i && (starve_cnt_q == StarveMax)) begin
          state_d      = StBusyI;
          mem_req_d    = 1'b1;
          addr_sel_d   = 1'b0;
          mem_we_d     = 1'b0;
          busy_d       = 1'b1;
          starve_cnt_d = '0;
        end else if (d_req_i) begin
          state_d    = StBusyD;
          mem_req_d  = 1'b1;
          addr_sel_d = 1'b1;
          mem_we_d   = d_we_i;
          busy_d     = 1'b1;
          if (!if_req_i) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (if_req_i) begin
          state_d      = StBusyI;
          mem_req_d    = 1'b1;
          addr_sel_d   = 1'b0;
          mem_we_d     = 1'b0;
          busy_d       = 1'b1;
          starve_cnt_d = '0;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ready_i || abort) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          addr_sel_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_sel_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      addr_sel_q   <= addr_sel_d;
      busy_q       <= busy_d;
    end
  end

  // An aborted access still acks so the stalled stage can move on.
  assign if_ack_o   = (state_q == StBusyI) && (mem_ready_i || abort);
  assign d_ack_o    = (state_q == StBusyD) && (mem_ready_i || abort);
  assign err_o      = abort;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign addr_sel_o = addr_sel_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_MAX=3, TIMEOUT=8).
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  logic if_req, d_req, d_we, mem_ready;
  logic mem_req, mem_we, addr_sel, if_ack, d_ack, busy, err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .STARVE_MAX(3),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req_i   (if_req),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .mem_ready_i(mem_ready),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .addr_sel_o (addr_sel),
    .if_ack_o   (if_ack),
    .d_ack_o    (d_ack),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_req"},  32'(mem_req),  0);
    check({tag, ".mem_we"},   32'(mem_we),   0);
    check({tag, ".addr_sel"}, 32'(addr_sel), 0);
    check({tag, ".if_ack"},   32'(if_ack),   0);
    check({tag, ".d_ack"},    32'(d_ack),    0);
    check({tag, ".busy"},     32'(busy),     0);
    check({tag, ".err"},      32'(err),      0);
  endtask

  logic [7:0] exp_sel;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle.busy", 32'(busy), 0);
    end

    // Single fetch, mem_ready two cycles after mem_req
    if_req = 1'b1;
    tick();
    check("fetch.mem_req", 32'(mem_req), 1);
    check("fetch.addr_sel", 32'(addr_sel), 0);
    check("fetch.mem_we", 32'(mem_we), 0);
    check("fetch.early_ack", 32'(if_ack), 0);
    tick();
    check("fetch.wait_ack", 32'(if_ack), 0);
    tick();
    mem_ready = 1'b1;
    #1;
    check("fetch.if_ack", 32'(if_ack), 1);
    check("fetch.d_ack", 32'(d_ack), 0);
    tick();
    if_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("fetch.busy_after", 32'(busy), 0);
    check("fetch.ack_after", 32'(if_ack), 0);
    check("fetch.mem_req_after", 32'(mem_req), 0);

    // Both requesters held: D,D,D,I,D,D,D,I
    exp_sel = 8'b0111_0111;
    if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("prio.busy", 32'(busy), 1);
      check("prio.addr_sel", 32'(addr_sel), 32'(exp_sel[i]));
      check("prio.d_ack", 32'(d_ack), 32'(exp_sel[i]));
      check("prio.if_ack", 32'(if_ack), 32'(!exp_sel[i]));
      tick();
      check("prio.bubble", 32'(busy), 0);
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Data write: mem_we latched at grant
    d_req = 1'b1; d_we = 1'b1;
    tick();
    check("wr.mem_we", 32'(mem_we), 1);
    check("wr.addr_sel", 32'(addr_sel), 1);
    d_we = 1'b0;
    tick();
    check("wr.mem_we_held", 32'(mem_we), 1);
    check("wr.no_ack", 32'(d_ack), 0);
    mem_ready = 1'b1;
    #1;
    check("wr.d_ack", 32'(d_ack), 1);
    check("wr.mem_we_at_ack", 32'(mem_we), 1);
    tick();
    d_req = 1'b0;
    #1;
    check("wr.idle_mem_we", 32'(mem_we), 0);
    check("wr.idle_d_ack", 32'(d_ack), 0);
    check("wr.idle_if_ack", 32'(if_ack), 0);
    tick();
    check("wr.idle_busy", 32'(busy), 0);
    check("wr.idle_d_ack2", 32'(d_ack), 0);
    mem_ready = 1'b0;

    // Asynchronous reset mid BUSY_D
    d_req = 1'b1; d_we = 1'b1;
    tick();
    check("arst.pre_mem_req", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_all_zero("arst");
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst.regrant_busy", 32'(busy), 1);
    check("arst.regrant_sel", 32'(addr_sel), 1);
    check("arst.regrant_we", 32'(mem_we), 1);
    mem_ready = 1'b1;
    tick();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();

`ifdef ARB_WDOG_EN
    // Watchdog: abort in the 8th BUSY_I cycle
    if_req = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      check("wdog.err", 32'(err), 32'(c == 8));
      check("wdog.if_ack", 32'(if_ack), 32'(c == 8));
      if (c < 8) tick();
    end
    tick();
    if_req = 1'b0;
    #1;
    check("wdog.idle_busy", 32'(busy), 0);
    check("wdog.idle_err", 32'(err), 0);
`else
    // No watchdog: stalls indefinitely, err stays 0
    if_req = 1'b1;
    tick();
    repeat (20) tick();
    check("nowdog.busy", 32'(busy), 1);
    check("nowdog.err", 32'(err), 0);
    check("nowdog.if_ack", 32'(if_ack), 0);
    mem_ready = 1'b1;
    #1;
    check("nowdog.late_ack", 32'(if_ack), 1);
    tick();
    if_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("nowdog.idle_busy", 32'(busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
